// File: rtl/datamemory_lsu.sv
// ---------------------------------------------------------------------------
// datamemory_lsu
//
// Handshaked load/store unit with an internal byte-addressable synchronous
// RAM of 2^DM_ADDRESS bytes. The data path is DATA_W bits wide (32 or 64).
// It sits between the execute/memory stage and writeback.
//
// Each access walks IDLE -> ACCESS -> RESP. A response is visible to the
// consumer two edges after the request was accepted. Back-to-back requests
// complete one access every two cycles.
//
// Optional feature macro: DM_FAULT_EN
//   defined   : misaligned or illegal accesses leave the RAM untouched and
//               return rsp_err=1 with rsp_rdata=0.
//   undefined : rsp_err is always 0. Misaligned addresses are forced to
//               alignment. An illegal funct3 becomes a full-width access.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   req_valid   request present
//   req_ready   unit can accept a request this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  instruction bits 14:12 (access size / signedness)
//   req_addr    byte address
//   req_wdata   store data, LSB-justified
//   rsp_valid   response present
//   rsp_ready   consumer accepts the response
//   rsp_rdata   extended load data; 0 for stores and faults
//   rsp_err     access fault (misaligned or illegal funct3)
// ---------------------------------------------------------------------------
module datamemory_lsu #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int IDX_W = DM_ADDRESS - OFS_W;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [DM_ADDRESS-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DATA_W-1:0]       ram_rdata_q;

    // Access decode
    logic [1:0]              size_lg;     // log2(bytes accessed)
    logic [3:0]              nbytes;
    logic                    is_signed;
    logic                    illegal;
    logic                    fault;
    logic [OFS_W-1:0]        off;
    logic [OFS_W-1:0]        size_mask;
    logic [OFS_W-1:0]        eff_off;
    logic [IDX_W-1:0]        widx;

    logic [NB-1:0]           be;
    logic [DATA_W-1:0]       wr_word;
    logic [DATA_W-1:0]       shifted;
    logic [DATA_W-1:0]       load_ext;

    // -----------------------------------------------------------------------
    // Handshake: RESP frees the unit in the same cycle the response is taken.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so that no path leaves it unassigned and a latch is never inferred.
        req_ready = 1'b0;
        case (state_q)
            IDLE:    req_ready = 1'b1;
            RESP:    req_ready = rsp_ready;
            default: req_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = req_valid ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
        if (req_valid && req_ready) begin
            we_d     = req_we;
            funct3_d = req_funct3;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
        end
    end

    // NOTE: clocked blocks use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop; combinational blocks use
    // blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Size / sign / legality decode of the latched request
    // -----------------------------------------------------------------------
    always_comb begin
        size_lg   = 2'(OFS_W);
        is_signed = 1'b0;
        illegal   = 1'b0;
        case (funct3_q)
            3'b000: begin size_lg = 2'd0; is_signed = 1'b1; end
            3'b001: begin size_lg = 2'd1; is_signed = 1'b1; end
            3'b010: begin size_lg = 2'd2; is_signed = 1'b1; end
            3'b011: begin
                if (DATA_W == 64) size_lg = 2'd3;
                else              illegal = 1'b1;
            end
            3'b100: size_lg = 2'd0;
            3'b101: size_lg = 2'd1;
            3'b110: begin
                if (DATA_W == 64) size_lg = 2'd2;
                else              illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (we_q && funct3_q[2]) illegal = 1'b1;

        off  = addr_q[OFS_W-1:0];
        widx = addr_q[DM_ADDRESS-1:OFS_W];
`ifdef DM_FAULT_EN
        size_mask = OFS_W'((1 << size_lg) - 1);
        fault     = illegal || ((off & size_mask) != '0);
        eff_off   = off;
`else
        if (illegal) begin
            size_lg   = 2'(OFS_W);
            is_signed = 1'b0;
        end
        size_mask = OFS_W'((1 << size_lg) - 1);
        fault     = 1'b0;
        eff_off   = off & ~size_mask;
`endif
        nbytes = 4'd1 << size_lg;
    end

    // -----------------------------------------------------------------------
    // Store lanes: the data is replicated at its own size across the word,
    // so whichever lanes are enabled already carry the LSBs of wdata.
    // -----------------------------------------------------------------------
    always_comb begin
        be      = '0;
        wr_word = '0;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(eff_off)) && (i < int'(eff_off) + int'(nbytes));
            wr_word[8*i +: 8] = wdata_q[8*(i & (int'(nbytes) - 1)) +: 8];
        end
    end

    // -----------------------------------------------------------------------
    // Load extraction: shift the addressed lane down, then sign/zero extend.
    // -----------------------------------------------------------------------
    always_comb begin
        shifted  = ram_rdata_q >> {eff_off, 3'b000};
        load_ext = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (j < 8 * int'(nbytes)) load_ext[j] = shifted[j];
            else                      load_ext[j] = is_signed & shifted[8*int'(nbytes) - 1];
        end
    end

    // -----------------------------------------------------------------------
    // RAM: synchronous read and byte-lane write, both during ACCESS. The
    // write is gated by reset so a reset in ACCESS abandons the store.
    // -----------------------------------------------------------------------
    // NOTE: the RAM array and its read register have no reset; their contents
    // are only meaningful once written, and resetting a memory would defeat
    // RAM inference.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && !reset) begin
            if (we_q && !fault) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) mem[widx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
            ram_rdata_q <= mem[widx];
        end
    end

    // Response fields derive only from registered state, so they stay stable
    // for as long as RESP is held by back-pressure.
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && fault;
    assign rsp_rdata = (rsp_valid && !we_q && !fault) ? load_ext : '0;

endmodule

// File: tb/tb_datamemory_lsu.sv
// ---------------------------------------------------------------------------
// tb_datamemory_lsu
//
// Drives a 32-bit and a 64-bit datamemory_lsu through one shared request
// bus (sel picks the target). Expected responses are queued when a request
// is accepted and compared when the response appears.
// ---------------------------------------------------------------------------
module tb_datamemory_lsu;

    typedef struct {
        string       tag;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_ready;

    logic        rr32, rv32, re32;
    logic [31:0] rd32;
    logic        rr64, rv64, re64;
    logic [63:0] rd64;

    logic        req_ready_m;
    logic        rsp_valid_m;
    logic        rsp_err_m;
    logic [63:0] rsp_rdata_m;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32)) u_dut32 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid && !sel),
        .req_ready  (rr32),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata[31:0]),
        .rsp_valid  (rv32),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rd32),
        .rsp_err    (re32)
    );

    datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(64)) u_dut64 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid && sel),
        .req_ready  (rr64),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rv64),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rd64),
        .rsp_err    (re64)
    );

    assign req_ready_m = sel ? rr64 : rr32;
    assign rsp_valid_m = sel ? rv64 : rv32;
    assign rsp_err_m   = sel ? re64 : re32;
    assign rsp_rdata_m = sel ? rd64 : {32'h0, rd32};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request and hold it until accepted; queue its expectation.
    task automatic send(input logic s, input string tag, input logic we, input logic [2:0] f3,
                        input logic [8:0] a, input logic [63:0] wd,
                        input logic [63:0] er, input logic ee);
        int t;
        sel        = s;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        t = 0;
        while (!req_ready_m && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check({tag, "_accept"}, 64'(req_ready_m), 64'd1);
        @(posedge clk);
        sb.push_back('{tag, er, ee});
        #1 req_valid = 1'b0;
    endtask

    // Wait for the response (rsp_ready held 1), pop and compare.
    task automatic recv(input logic chk_lat);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid_m && n < 20);
        check("rsp_valid", 64'(rsp_valid_m), 64'd1);
        check("sb_depth", 64'(sb.size()), 64'd1);
        if (sb.size() != 0) e = sb.pop_front();
        else                e = '{"none", 64'h0, 1'b0};
        if (chk_lat) check({e.tag, "_lat"}, 64'(n), 64'd2);
        check({e.tag, "_rdata"}, rsp_rdata_m, e.rdata);
        check({e.tag, "_err"}, 64'(rsp_err_m), 64'(e.err));
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic s, input string tag, input logic we, input logic [2:0] f3,
                       input logic [8:0] a, input logic [63:0] wd,
                       input logic [63:0] er, input logic ee);
        send(s, tag, we, f3, a, wd, er, ee);
        recv(1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_sh_word, exp_lw12, exp_ill_ld, exp_w14;
        logic        exp_flt;
        int          t;
        exp_t        e;

`ifdef DM_FAULT_EN
        exp_flt     = 1'b1;
        exp_sh_word = 64'hDE7FBEEF;
        exp_lw12    = 64'h0;
        exp_ill_ld  = 64'h0;
        exp_w14     = 64'h55AA55AA;
`else
        exp_flt     = 1'b0;
        exp_sh_word = 64'hDE7FABCD;
        exp_lw12    = 64'hDE7FABCD;
        exp_ill_ld  = 64'hDE7FABCD;
        exp_w14     = 64'h12345678;
`endif

        sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid_m), 64'd0);
        check("rst_req_ready", 64'(req_ready_m), 64'd1);
        check("rst_rsp_rdata", rsp_rdata_m, 64'd0);
        check("rst_rsp_err", 64'(rsp_err_m), 64'd0);

        // 32-bit: basic store/load and sub-word access
        txn(0, "sw10",  1, 3'b010, 9'h010, 64'hDEADBEEF, 64'h0, 0);
        txn(0, "lw10",  0, 3'b010, 9'h010, 64'h0, 64'hDEADBEEF, 0);
        txn(0, "sb12",  1, 3'b000, 9'h012, 64'h7F, 64'h0, 0);
        txn(0, "lw10b", 0, 3'b010, 9'h010, 64'h0, 64'hDE7FBEEF, 0);
        txn(0, "lb13",  0, 3'b000, 9'h013, 64'h0, 64'hFFFFFFDE, 0);
        txn(0, "lbu13", 0, 3'b100, 9'h013, 64'h0, 64'h000000DE, 0);
        txn(0, "lh12",  0, 3'b001, 9'h012, 64'h0, 64'hFFFFDE7F, 0);
        txn(0, "lhu12", 0, 3'b101, 9'h012, 64'h0, 64'h0000DE7F, 0);

        // Back-pressure: hold RESP for 5 cycles with a new request waiting
        rsp_ready = 1'b0;
        send(0, "bp_lw", 0, 3'b010, 9'h010, 64'h0, 64'hDE7FBEEF, 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rsp_valid_m && t < 20);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 9'h010;
        repeat (5) begin
            check("bp_valid", 64'(rsp_valid_m), 64'd1);
            check("bp_rdata", rsp_rdata_m, (sb.size() != 0) ? sb[0].rdata : 64'hX);
            check("bp_req_ready", 64'(req_ready_m), 64'd0);
            @(negedge clk);
        end
        if (sb.size() != 0) e = sb.pop_front();
        else                e = '{"none", 64'h0, 1'b0};
        check("bp_final_rdata", rsp_rdata_m, e.rdata);
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready_m), 64'd1);
        @(posedge clk);
        sb.push_back('{"bp_next_lbu", 64'h000000EF, 1'b0});
        #1 req_valid = 1'b0;
        recv(1'b1);

        // Misaligned / illegal handling
        txn(0, "sh11",   1, 3'b001, 9'h011, 64'hABCD, 64'h0, exp_flt);
        txn(0, "lw10c",  0, 3'b010, 9'h010, 64'h0, exp_sh_word, 0);
        txn(0, "lw12",   0, 3'b010, 9'h012, 64'h0, exp_lw12, exp_flt);
        txn(0, "ill_ld", 0, 3'b111, 9'h010, 64'h0, exp_ill_ld, exp_flt);
        txn(0, "sw14",   1, 3'b010, 9'h014, 64'h55AA55AA, 64'h0, 0);
        txn(0, "ill_st", 1, 3'b100, 9'h014, 64'h12345678, 64'h0, exp_flt);
        txn(0, "lw14",   0, 3'b010, 9'h014, 64'h0, exp_w14, 0);

        // Reset during ACCESS suppresses the store
        txn(0, "sw20", 1, 3'b010, 9'h020, 64'h11223344, 64'h0, 0);
        send(0, "sw20_rst", 1, 3'b010, 9'h020, 64'hCAFEF00D, 64'h0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        if (sb.size() != 0) e = sb.pop_back();
        @(negedge clk);
        check("rstacc_rsp_valid", 64'(rsp_valid_m), 64'd0);
        check("rstacc_req_ready", 64'(req_ready_m), 64'd1);
        txn(0, "lw20", 0, 3'b010, 9'h020, 64'h0, 64'h11223344, 0);

        // Reset during RESP drops the response
        rsp_ready = 1'b0;
        send(0, "lw20_drop", 0, 3'b010, 9'h020, 64'h0, 64'h11223344, 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rsp_valid_m && t < 20);
        check("drop_pre_valid", 64'(rsp_valid_m), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        if (sb.size() != 0) e = sb.pop_back();
        @(negedge clk);
        check("drop_rsp_valid", 64'(rsp_valid_m), 64'd0);
        rsp_ready = 1'b1;

        // 64-bit instance
        txn(1, "sd08",   1, 3'b011, 9'h008, 64'h8000000012345678, 64'h0, 0);
        txn(1, "lwu0c",  0, 3'b110, 9'h00C, 64'h0, 64'h0000000080000000, 0);
        txn(1, "lw0c",   0, 3'b010, 9'h00C, 64'h0, 64'hFFFFFFFF80000000, 0);
        txn(1, "ld08",   0, 3'b011, 9'h008, 64'h0, 64'h8000000012345678, 0);
        txn(1, "lh0e",   0, 3'b001, 9'h00E, 64'h0, 64'hFFFFFFFFFFFF8000, 0);
        txn(1, "lb0b",   0, 3'b000, 9'h00B, 64'h0, 64'h0000000000000012, 0);
        txn(1, "sb0f",   1, 3'b000, 9'h00F, 64'h5A, 64'h0, 0);
        txn(1, "ld08b",  0, 3'b011, 9'h008, 64'h0, 64'h5A00000012345678, 0);
        txn(1, "lbu0f",  0, 3'b100, 9'h00F, 64'h0, 64'h000000000000005A, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
